win_checker: RTL and testbench

Downstream stage of the column-select / piece-placement FSM. It consumes that stage's board register (`panel_out`) and produces the `win` flag that the FSM samples in its WAIT state. On a start pulse it snapshots the 7×6 board and scans it one cell per cycle, checking four line directions at each cell for four equal pieces. It reports the first winning line in scan order, the winning player and, optionally, a mask of the winning cells.

---
 rtl/win_checker.sv | 180 ++++++++++++++++++
 tb/tb_win_checker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/win_checker.sv
// win_checker: scans a snapshot of the 7x6 board, one cell per cycle, for
// four equal pieces in a row (H, V, rising and falling diagonal).
// Optional feature macro: WIN_CHECKER_MASK_EN builds the winning-cell mask
// register; without it win_mask is tied to zero.
module win_checker (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0][5:0][1:0]  panel_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  win,
  output logic                  winner,
  output logic [6:0][5:0]       win_mask
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t               state_q, state_d;
  logic [6:0][5:0][1:0] board_q, board_d;
  logic [2:0]           col_q, col_d;
  logic [2:0]           row_q, row_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 win_q, win_d;
  logic                 winner_q, winner_d;

  logic                 hit_h, hit_v, hit_d1, hit_d2, hit;
  logic                 last_cell;
  logic [1:0]           anchor;
  int                   col_i, row_i;

  // Off-board coordinates read as the illegal code so such windows never match
  function automatic logic [1:0] cell_at(input logic [6:0][5:0][1:0] b,
                                         input int c, input int r);
    logic [1:0] v;
    v = 2'b11;
    if (c >= 0 && c <= 6 && r >= 0 && r <= 5) v = b[c[2:0]][r[2:0]];
    return v;
  endfunction

  // A line matches when all four cells equal the anchor and the anchor is a player
  function automatic logic line_match(input logic [6:0][5:0][1:0] b,
                                      input int c, input int r,
                                      input int dc, input int dr);
    logic [1:0] a;
    logic       ok;
    a  = cell_at(b, c, r);
    ok = (a == 2'b01) || (a == 2'b10);
    for (int k = 1; k < 4; k++) begin
      if (cell_at(b, c + k * dc, r + k * dr) != a) ok = 1'b0;
    end
    return ok;
  endfunction

  assign col_i     = {29'd0, col_q};
  assign row_i     = {29'd0, row_q};
  assign anchor    = board_q[col_q][row_q];
  assign last_cell = (col_q == 3'd6) && (row_q == 3'd5);

  // Evaluate the four windows anchored at the current scan cell
  always_comb begin
    hit_h  = line_match(board_q, col_i, row_i, 1, 0);
    hit_v  = line_match(board_q, col_i, row_i, 0, 1);
    hit_d1 = line_match(board_q, col_i, row_i, 1, 1);
    hit_d2 = line_match(board_q, col_i, row_i, 1, -1);
    hit    = hit_h || hit_v || hit_d1 || hit_d2;
  end

  // Next-state logic: a new scan may start from IDLE or DONE unless the game is won
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: state_d = (start && !win_q) ? SCAN : IDLE;
      SCAN:       if (hit || last_cell) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Output and datapath next values: snapshot capture, scan position, result flags
  always_comb begin
    board_d  = board_q;
    col_d    = col_q;
    row_d    = row_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    win_d    = win_q;
    winner_d = winner_q;
    if (state_q != SCAN) begin
      if (start && !win_q) begin
        board_d = panel_in;
        col_d   = 3'd0;
        row_d   = 3'd0;
        busy_d  = 1'b1;
      end
    end else if (hit) begin
      win_d    = 1'b1;
      winner_d = (anchor == 2'b10);
      done_d   = 1'b1;
    end else if (last_cell) begin
      done_d = 1'b1;
    end else begin
      busy_d = 1'b1;
      if (row_q == 3'd5) begin
        row_d = 3'd0;
        col_d = col_q + 3'd1;
      end else begin
        row_d = row_q + 3'd1;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      board_q  <= '0;
      col_q    <= 3'd0;
      row_q    <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      win_q    <= 1'b0;
      winner_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      col_q    <= col_d;
      row_q    <= row_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      win_q    <= win_d;
      winner_q <= winner_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign win    = win_q;
  assign winner = winner_q;

`ifdef WIN_CHECKER_MASK_EN
  logic [6:0][5:0] mask_q, mask_d, hit_mask;

  // Cells of a line starting at the anchor, stepping by (dc, dr)
  function automatic logic [6:0][5:0] line_mask(input int c, input int r,
                                                input int dc, input int dr);
    logic [6:0][5:0] m;
    int              cc, rr;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      cc = c + k * dc;
      rr = r + k * dr;
      m[cc[2:0]][rr[2:0]] = 1'b1;
    end
    return m;
  endfunction

  // Mask of the highest-priority matching window (H, V, D1, D2)
  always_comb begin
    hit_mask = '0;
    if (hit_h)       hit_mask = line_mask(col_i, row_i, 1, 0);
    else if (hit_v)  hit_mask = line_mask(col_i, row_i, 0, 1);
    else if (hit_d1) hit_mask = line_mask(col_i, row_i, 1, 1);
    else if (hit_d2) hit_mask = line_mask(col_i, row_i, 1, -1);
    mask_d = mask_q;
    if (state_q == SCAN && hit) mask_d = hit_mask;
  end

  // Winning-cell mask register, held until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mask_q <= '0;
    else     mask_q <= mask_d;
  end

  assign win_mask = mask_q;
`else
  assign win_mask = '0;
`endif

endmodule

// File: tb/tb_win_checker.sv
// Directed testbench for win_checker with hand-computed scan latencies.
module tb_win_checker;

  logic                 clk;
  logic                 rst;
  logic [6:0][5:0][1:0] panel_in;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 win;
  logic                 winner;
  logic [6:0][5:0]      win_mask;

  int checkCount;
  int failCount;

  logic [6:0][5:0][1:0] board;
  logic [6:0][5:0]      mask;
  int                   doneSeen;
  int                   busySeen;

  win_checker dut (
    .clk      (clk),
    .rst      (rst),
    .panel_in (panel_in),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .win      (win),
    .winner   (winner),
    .win_mask (win_mask)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected mask value depends on whether the mask register is built
  function automatic logic [6:0][5:0] expMask(input logic [6:0][5:0] m);
`ifdef WIN_CHECKER_MASK_EN
    return m;
`else
    return (m & '0);
`endif
  endfunction

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulse start with a board, watch 60 cycles and check latency and results.
  // expDone: cycle after the start edge in which done is expected (0 = none).
  task automatic applyStimulus(input string tag,
                               input logic [6:0][5:0][1:0] b,
                               input int expDone, input logic expWin,
                               input logic expWinner,
                               input logic [6:0][5:0] expM,
                               input int extraAt, input bit scramble);
    int doneCount, firstDone, busyCount;
    doneCount = 0;
    firstDone = 0;
    busyCount = 0;
    @(negedge clk);
    panel_in = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (scramble) panel_in = {42{2'b01}};
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (busy) busyCount++;
      if (done) begin
        doneCount++;
        if (firstDone == 0) firstDone = cyc;
      end
      start = (cyc == extraAt);
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput({tag, "_doneCount"}, doneCount, (expDone != 0) ? 1 : 0);
    checkOutput({tag, "_doneCycle"}, firstDone, expDone);
    checkOutput({tag, "_busyCycles"}, busyCount, (expDone != 0) ? expDone - 1 : 0);
    checkOutput({tag, "_win"}, win, expWin);
    checkOutput({tag, "_winner"}, winner, expWinner);
    checkOutput({tag, "_mask"}, win_mask, expMask(expM));
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst = 1'b1;
    start = 1'b0;
    panel_in = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_win", win, 1'b0);
    checkOutput("rst_winner", winner, 1'b0);
    checkOutput("rst_mask", win_mask, '0);
    rst = 1'b0;

    $display("[TB] empty board, panel_in changed after start");
    board = '0;
    applyStimulus("empty", board, 43, 1'b0, 1'b0, '0, 0, 1'b1);

    $display("[TB] vertical player 0 in column 3");
    applyReset();
    board = '0;
    for (int r = 0; r < 4; r++) board[3][r] = 2'b01;
    mask = '0;
    for (int r = 0; r < 4; r++) mask[3][r] = 1'b1;
    applyStimulus("vert", board, 20, 1'b1, 1'b0, mask, 0, 1'b0);
    applyStimulus("afterWin", '0, 0, 1'b1, 1'b0, mask, 0, 1'b0);

    $display("[TB] player 1 H and V sharing anchor (2,0)");
    applyReset();
    board = '0;
    mask = '0;
    for (int k = 0; k < 4; k++) begin
      board[2 + k][0] = 2'b10;
      board[2][k] = 2'b10;
      mask[2 + k][0] = 1'b1;
    end
    applyStimulus("hvPrio", board, 14, 1'b1, 1'b1, mask, 0, 1'b0);

    $display("[TB] rising diagonal player 1 from (1,1)");
    applyReset();
    board = '0;
    mask = '0;
    for (int k = 0; k < 4; k++) begin
      board[1 + k][1 + k] = 2'b10;
      mask[1 + k][1 + k] = 1'b1;
    end
    applyStimulus("diag1", board, 9, 1'b1, 1'b1, mask, 0, 1'b0);

    $display("[TB] falling diagonal player 0 from (0,3)");
    applyReset();
    board = '0;
    mask = '0;
    for (int k = 0; k < 4; k++) begin
      board[k][3 - k] = 2'b01;
      mask[k][3 - k] = 1'b1;
    end
    applyStimulus("diag2", board, 5, 1'b1, 1'b0, mask, 0, 1'b0);

    $display("[TB] illegal-code lines and start while busy");
    applyReset();
    board = '0;
    for (int r = 0; r < 4; r++) board[0][r] = 2'b11;
    for (int c = 0; c < 7; c++) board[c][5] = 2'b11;
    applyStimulus("illegal", board, 43, 1'b0, 1'b0, '0, 10, 1'b0);

    $display("[TB] reset in the middle of a winning scan");
    applyReset();
    board = '0;
    for (int r = 0; r < 4; r++) board[3][r] = 2'b01;
    @(negedge clk);
    panel_in = board;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("abort_busyBefore", busy, 1'b1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_done", done, 1'b0);
    checkOutput("abort_win", win, 1'b0);
    checkOutput("abort_mask", win_mask, '0);
    @(negedge clk);
    rst = 1'b0;
    doneSeen = 0;
    busySeen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done) doneSeen++;
      if (busy) busySeen++;
      @(negedge clk);
    end
    checkOutput("abort_noDone", doneSeen, 0);
    checkOutput("abort_noBusy", busySeen, 0);
    mask = '0;
    for (int r = 0; r < 4; r++) mask[3][r] = 1'b1;
    applyStimulus("rescan", board, 20, 1'b1, 1'b0, mask, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
